exc_seq: RTL and testbench

- Exception/interrupt sequencer for the CP0 register file.
- Detects interrupts, synchronous exceptions and ERET at the MEM stage, then flushes the pipeline.
- Drives the single CP0 write port through a multi-cycle EPC/Cause/Status update, then redirects the PC.
- Arbitrates that write port between its own sequence and MTC0 writes arriving from WB.

---
 rtl/exc_seq.sv | 139 +++++++++++++
 tb/tb_exc_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: flushes on an event at MEM, then walks the CP0 write
// port through EPC/Cause/Status updates and finally redirects the PC.
module exc_seq #(
  parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
  parameter logic [4:0]  STATUS_ADDR = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic [31:0] exc_pc_i,
  input  logic        in_delay_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        pc_load_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  // state    | meaning
  // IDLE     | sampling events, MTC0 owns the write port
  // W_EPC    | writing EPC (skipped when EXL already set)
  // W_CAUSE  | writing Cause with BD and ExcCode
  // W_STATUS | setting EXL (exception) or clearing it (ERET)
  // REDIRECT | one-cycle PC load
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [4:0]  code_q;
  logic        bd_q, eret_q;
  logic [31:0] epcv_q, status_q, cause_q, epc_q, new_pc_q;
  logic        int_pend, take_exc, take_eret;
  logic [4:0]  code_d;

  assign int_pend  = inst_valid_i & status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign take_exc  = (state == IDLE) & (int_pend | (inst_valid_i & exc_req_i));
  assign take_eret = (state == IDLE) & ~take_exc & inst_valid_i & eret_i;
  assign code_d    = int_pend ? 5'd0 : exc_code_i;
  assign new_pc_o  = new_pc_q;

  always_comb begin
    state_nxt   = state;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_wdata_o = 32'd0;
    flush_o     = 1'b0;
    stall_o     = 1'b0;
    pc_load_o   = 1'b0;
    busy_o      = 1'b0;
    case (state)
      IDLE: begin
        // the WB instruction is older than the event, so its MTC0 still lands
        cp0_we_o    = mtc0_we_i;
        cp0_waddr_o = mtc0_addr_i;
        cp0_wdata_o = mtc0_data_i;
        if (take_exc) begin
          flush_o   = 1'b1;
          state_nxt = status_i[1] ? W_CAUSE : W_EPC;
        end else if (take_eret) begin
          flush_o   = 1'b1;
          state_nxt = W_STATUS;
        end
      end
      W_EPC: begin
        stall_o     = 1'b1;
        busy_o      = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = EPC_ADDR;
        cp0_wdata_o = epcv_q;
        state_nxt   = W_CAUSE;
      end
      W_CAUSE: begin
        stall_o     = 1'b1;
        busy_o      = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CAUSE_ADDR;
        cp0_wdata_o = {bd_q, cause_q[30:7], code_q, cause_q[1:0]};
        state_nxt   = W_STATUS;
      end
      W_STATUS: begin
        stall_o     = 1'b1;
        busy_o      = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = STATUS_ADDR;
        cp0_wdata_o = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
        state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        stall_o   = 1'b1;
        busy_o    = 1'b1;
        pc_load_o = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      code_q   <= 5'd0;
      bd_q     <= 1'b0;
      eret_q   <= 1'b0;
      epcv_q   <= 32'd0;
      status_q <= 32'd0;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
      new_pc_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (take_exc || take_eret) begin
        code_q   <= code_d;
        bd_q     <= in_delay_i;
        eret_q   <= take_eret;
        epcv_q   <= in_delay_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        status_q <= status_i;
        cause_q  <= cause_i;
        epc_q    <= epc_i;
      end
      // loaded on entry to REDIRECT and held afterwards
      if (state == W_STATUS)
        new_pc_q <= eret_q ? epc_q : EXC_VECTOR;
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: directed scenarios then random traffic, checked against a
// per-event plan of expected write-port cycles.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, exc_req_i, eret_i, in_delay_i, mtc0_we_i;
  logic [4:0]  exc_code_i, mtc0_addr_i;
  logic [31:0] exc_pc_i, status_i, cause_i, epc_i, mtc0_data_i;
  logic        cp0_we_o, flush_o, stall_o, pc_load_o, busy_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o, new_pc_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        pl;
    logic [31:0] npc;
  } rec_t;

  rec_t        plan[$];
  logic [31:0] last_pc = 32'd0;

  exc_seq dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .exc_req_i(exc_req_i), .exc_code_i(exc_code_i),
    .eret_i(eret_i), .exc_pc_i(exc_pc_i), .in_delay_i(in_delay_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .mtc0_we_i(mtc0_we_i), .mtc0_addr_i(mtc0_addr_i), .mtc0_data_i(mtc0_data_i),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .flush_o(flush_o), .stall_o(stall_o), .pc_load_o(pc_load_o),
    .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    inst_valid_i = 0; exc_req_i = 0; exc_code_i = 0; eret_i = 0;
    exc_pc_i = 0; in_delay_i = 0; status_i = 0; cause_i = 0; epc_i = 0;
    mtc0_we_i = 0; mtc0_addr_i = 0; mtc0_data_i = 0;
  endtask

  // One cycle: check outputs mid-cycle against the plan, then advance the plan.
  task automatic step();
    rec_t        r;
    logic        ipend, ev_exc, ev_eret;
    logic [4:0]  code;
    logic [31:0] epcv, cz;
    @(negedge clk);
    if (plan.size() == 0) begin
      ipend   = inst_valid_i && status_i[0] && !status_i[1] &&
                ((cause_i[15:8] & status_i[15:8]) != 8'd0);
      ev_exc  = ipend || (inst_valid_i && exc_req_i);
      ev_eret = !ev_exc && inst_valid_i && eret_i;
      code    = ipend ? 5'd0 : exc_code_i;
      chk("flush", {31'd0, flush_o}, {31'd0, ev_exc || ev_eret});
      chk("stall", {31'd0, stall_o}, 32'd0);
      chk("busy", {31'd0, busy_o}, 32'd0);
      chk("pc_load", {31'd0, pc_load_o}, 32'd0);
      chk("new_pc", new_pc_o, last_pc);
      chk("we", {31'd0, cp0_we_o}, {31'd0, mtc0_we_i});
      chk("waddr", {27'd0, cp0_waddr_o}, {27'd0, mtc0_addr_i});
      chk("wdata", cp0_wdata_o, mtc0_data_i);
      if (ev_exc) begin
        epcv = in_delay_i ? exc_pc_i - 32'd4 : exc_pc_i;
        cz   = (cause_i & ~32'h8000_007C) | ({31'd0, in_delay_i} << 31) | ({27'd0, code} << 2);
        if (!status_i[1]) plan.push_back('{1'b1, 5'd14, epcv, 1'b0, 32'd0});
        plan.push_back('{1'b1, 5'd13, cz, 1'b0, 32'd0});
        plan.push_back('{1'b1, 5'd12, status_i | 32'h2, 1'b0, 32'd0});
        plan.push_back('{1'b0, 5'd0, 32'd0, 1'b1, 32'h20});
      end else if (ev_eret) begin
        plan.push_back('{1'b1, 5'd12, status_i & ~32'h2, 1'b0, 32'd0});
        plan.push_back('{1'b0, 5'd0, 32'd0, 1'b1, epc_i});
      end
    end else begin
      r = plan.pop_front();
      if (r.pl) last_pc = r.npc;
      chk("flush_busy", {31'd0, flush_o}, 32'd0);
      chk("stall_busy", {31'd0, stall_o}, 32'd1);
      chk("busy_busy", {31'd0, busy_o}, 32'd1);
      chk("pc_load_seq", {31'd0, pc_load_o}, {31'd0, r.pl});
      chk("new_pc_seq", new_pc_o, last_pc);
      chk("we_seq", {31'd0, cp0_we_o}, {31'd0, r.we});
      chk("waddr_seq", {27'd0, cp0_waddr_o}, {27'd0, r.addr});
      chk("wdata_seq", cp0_wdata_o, r.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {31'd0, cp0_we_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_new_pc", new_pc_o, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step();

    // sync exception, EXL=0, with an explicit check of the T+4 target
    inst_valid_i = 1; exc_req_i = 1; exc_code_i = 5'h0C; exc_pc_i = 32'h100; status_i = 32'h1;
    step();
    idle_inputs();
    drain(3);
    @(negedge clk);
    chk("exc_pc_load_t4", {31'd0, pc_load_o}, 32'd1);
    chk("exc_new_pc_t4", new_pc_o, 32'h20);
    @(posedge clk); #1;
    last_pc = 32'h20;
    void'(plan.pop_front());
    step();

    // interrupt in delay slot, MTC0 to addr 11 passed through in the accept cycle
    inst_valid_i = 1; status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    exc_pc_i = 32'h204; in_delay_i = 1;
    mtc0_we_i = 1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'hCAFE_0011;
    step();
    idle_inputs();
    drain(4);

    // EXL already set: no EPC write, 3-cycle latency; MTC0 during busy ignored
    inst_valid_i = 1; exc_req_i = 1; exc_code_i = 5'h04; exc_pc_i = 32'h300; status_i = 32'h3;
    step();
    idle_inputs();
    mtc0_we_i = 1; mtc0_addr_i = 5'd9; mtc0_data_i = 32'h1234_5678;
    drain(3);
    idle_inputs();

    // ERET
    inst_valid_i = 1; eret_i = 1; epc_i = 32'h400; status_i = 32'h3;
    step();
    idle_inputs();
    drain(2);

    // interrupt wins over a simultaneous exception and eret
    inst_valid_i = 1; exc_req_i = 1; exc_code_i = 5'h0A; eret_i = 1;
    status_i = 32'h0000_8001; cause_i = 32'h0000_8000; exc_pc_i = 32'h500;
    step();
    idle_inputs();
    drain(4);

    // exception ignored without a valid instruction
    exc_req_i = 1; eret_i = 1; exc_code_i = 5'h08;
    step();
    idle_inputs();

    // reset during W_CAUSE
    inst_valid_i = 1; exc_req_i = 1; exc_code_i = 5'h0C; exc_pc_i = 32'h600; status_i = 32'h1;
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, cp0_we_o}, 32'd0);
    chk("mid_rst_waddr", {27'd0, cp0_waddr_o}, 32'd0);
    chk("mid_rst_wdata", cp0_wdata_o, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("mid_rst_pc_load", {31'd0, pc_load_o}, 32'd0);
    chk("mid_rst_new_pc", new_pc_o, 32'd0);
    plan.delete();
    last_pc = 32'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    drain(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      inst_valid_i = ($urandom_range(0, 3) != 0);
      exc_req_i    = ($urandom_range(0, 4) == 0);
      exc_code_i   = 5'($urandom());
      eret_i       = ($urandom_range(0, 4) == 0);
      exc_pc_i     = $urandom() & 32'hFFFF_FFFC;
      in_delay_i   = 1'($urandom());
      status_i     = $urandom();
      cause_i      = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() & 32'hFFFF_00FF);
      epc_i        = $urandom();
      mtc0_we_i    = 1'($urandom());
      mtc0_addr_i  = 5'($urandom());
      mtc0_data_i  = $urandom();
      step();
    end
    idle_inputs();
    drain(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
